disp_arbiter: RTL and testbench
===============================

# disp_arbiter

- Shares the 2-digit seven-segment display driver between four independent requesters.
- Grants the display to one requester at a time, round-robin, with a guaranteed minimum dwell time per grant.
- Drives the driver's 8-bit `Disp_Data` input from the granted requester's data.
- Sits between the application sources (counters, status, error codes) and `disp`. Only `Disp_Data` is connected to `disp`.

## Interface
Parameters:
- `MCNT_DWELL`, default 24_999_999: minimum grant duration minus one, in clock cycles. The default gives 0.5 s at 50 MHz.
- `IDLE_DATA`, default 8'h00: value driven on `Disp_Data` while no grant is held.

Ports:
- `Clk`  in  1  system clock. This is the block's only clock.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `Req`  in  4  level request per source. `Req[i]` is held high for as long as source i wants the display.
- `Req_Data`  in  32  display data per source. Source i uses `Req_Data[8i+7:8i]`.
- `Gnt`  out  4  registered one-hot grant, or all zero when idle.
- `Disp_Data`  out  8  registered data for `disp`.
- `Busy`  out  1  registered. Equals `|Gnt`.

## Operation
- The FSM has two states, IDLE and HOLD.
- Internal registers:
  - 2-bit round-robin pointer `ptr`, the first index searched.
  - 32-bit dwell counter `cnt_dwell`.
  - grant index `g`.
- **Reset values:** state=IDLE, `Gnt`=0, `Busy`=0, `Disp_Data`=`IDLE_DATA`, `ptr`=0, `cnt_dwell`=0. Reset asserted mid-grant clears everything immediately, asynchronously.
- **Arbitration event** occurs in a cycle when any one of these holds:
  - (a) the state is IDLE and `|Req`;
  - (b) the state is HOLD and `Req[g]`=0 (early release);
  - (c) the state is HOLD and `cnt_dwell`==`MCNT_DWELL` (dwell done).
- **Winner:** the first i with `Req[i]`=1, searching `ptr`, `ptr`+1, ... modulo 4.
  - Because `ptr` = g+1 after a grant, the current holder is searched last. It keeps the display only if no other source is requesting.
- **On an event with a winner w:**
  - `Gnt` <= one-hot(w), `g` <= w, `ptr` <= w+1 (wrapping 3 to 0).
  - `cnt_dwell` <= 0, state <= HOLD.
  - A winner equal to the current holder restarts its dwell.
- **On an event with no winner:** state <= IDLE, `Gnt` <= 0, `Disp_Data` <= `IDLE_DATA`. `ptr` is unchanged.
- **In HOLD with no event:**
  - `cnt_dwell` increments by 1. It never exceeds `MCNT_DWELL`.
  - `Disp_Data` <= `Req_Data` slice g, so data changes from the holder propagate continuously.
- **Grant hand-over** goes directly from one source to the next on a single edge, with no idle gap.
- At most one `Gnt` bit is set in any cycle.

## Timing
- **Grant latency:** `Req[i]` rising in cycle t while IDLE gives `Gnt[i]`, `Busy`, and `Disp_Data`=slice i after the edge ending cycle t. Latency is one clock.
- **Data latency:** `Disp_Data` lags `Req_Data` of the holder by one clock.
- **Minimum hold:** a holder that keeps `Req` high holds for exactly `MCNT_DWELL`+1 cycles before re-arbitration whenever a competitor is pending.
- **Early release:** `Req[g]` falling in cycle t frees the grant at the edge ending cycle t. The next winner, or IDLE, is visible after that edge.
- **Simultaneous events:** if dwell completion and holder drop coincide, the result is one arbitration, with the holder excluded because its `Req` is 0.

## Configuration
- **`DISP_ARB_PREEMPT_EN` defined:**
  - `Req[0]` high while in HOLD with g≠0 is an additional arbitration event, regardless of `cnt_dwell`.
  - Source 0 is granted at the next edge, `ptr` <= 1, and `cnt_dwell` <= 0.
  - Source 0 itself is never preempted.
- **`DISP_ARB_PREEMPT_EN` undefined:** source 0 is arbitrated like every other source. No preemption logic is compiled.

## Test plan
All scenarios use `MCNT_DWELL`=3.
- **Reset:** `Reset_n`=0, then 1 with `Req`=0. Expect `Gnt`=0, `Busy`=0, and `Disp_Data`=8'h00 held indefinitely.
- **Single requester:** `Req`=4'b0100, `Req_Data[23:16]`=8'h5A.
  - Expect `Gnt`=4'b0100 and `Disp_Data`=8'h5A one clock later.
  - The grant is retained across dwell expiries.
  - Changing the slice to 8'h3C is seen on `Disp_Data` one clock later.
- **Round-robin:** `Req`=4'b1111 from reset. Expect grants 0, 1, 2, 3, 0, each held for exactly 4 cycles, with no idle cycle between grants.
- **Early release:** source 1 is granted, and `Req[1]` drops after 1 cycle while `Req[3]`=1. Expect `Gnt`=4'b1000 at the next edge. With no other request pending, expect `Gnt`=0 and `Disp_Data`=8'h00.
- **Reset mid-grant:** assert `Reset_n`=0 while `Gnt`=4'b0010. Expect `Gnt`=0 and `Disp_Data`=8'h00 without waiting for a clock edge. After release with `Req`=4'b0010, expect the grant to return one clock later.
- **Preemption:** source 2 is granted at `cnt_dwell`=1, and `Req[0]` rises.
  - With `DISP_ARB_PREEMPT_EN` defined: expect `Gnt`=4'b0001 at the next edge.
  - Without it: `Gnt`=4'b0100 persists until `cnt_dwell`=3, then source 3 is granted if it is requesting, otherwise source 0.

Source files
------------

// File: rtl/disp_arbiter.sv
// Round-robin arbiter sharing the seven-segment display driver among four sources,
// with a minimum dwell per grant. Define DISP_ARB_PREEMPT_EN to let source 0 preempt.
module disp_arbiter #(
   parameter int unsigned MCNT_DWELL = 24_999_999,
   parameter logic [7:0]  IDLE_DATA  = 8'h00
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic [3:0]  Req,
   input  logic [31:0] Req_Data,
   output logic [3:0]  Gnt,
   output logic [7:0]  Disp_Data,
   output logic        Busy
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t      state_q, state_d;
   logic [1:0]  ptr, ptr_d;
   logic [1:0]  g, g_d;
   logic [31:0] cnt_dwell, cnt_d;
   logic [3:0]  gnt_d;
   logic [7:0]  data_d;
   logic        arb;
   logic        found;
   logic [1:0]  w;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= IDLE;
         ptr       <= '0;
         g         <= '0;
         cnt_dwell <= '0;
         Gnt       <= '0;
         Disp_Data <= IDLE_DATA;
         Busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr       <= ptr_d;
         g         <= g_d;
         cnt_dwell <= cnt_d;
         Gnt       <= gnt_d;
         Disp_Data <= data_d;
         Busy      <= |gnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr;
      g_d     = g;
      cnt_d   = cnt_dwell;
      gnt_d   = Gnt;
      data_d  = Disp_Data;
      found   = 1'b0;
      w       = ptr;

      // Search starts at ptr, so the current holder (ptr-1) is considered last.
      for (int unsigned k = 0; k < 4; k++) begin
         if (!found && Req[2'(ptr + 2'(k))]) begin
            found = 1'b1;
            w     = 2'(ptr + 2'(k));
         end
      end

      arb = ((state_q == IDLE) && (|Req)) ||
            ((state_q == HOLD) && (!Req[g] || (cnt_dwell == MCNT_DWELL)));

`ifdef DISP_ARB_PREEMPT_EN
      if ((state_q == HOLD) && (g != 2'd0) && Req[0]) begin
         arb   = 1'b1;
         found = 1'b1;
         w     = 2'd0;
      end
`endif

      if (arb) begin
         if (found) begin
            state_d = HOLD;
            gnt_d   = 4'b0001 << w;
            g_d     = w;
            ptr_d   = w + 2'd1;
            cnt_d   = '0;
            data_d  = Req_Data[{w, 3'b000} +: 8];
         end else begin
            state_d = IDLE;
            gnt_d   = '0;
            data_d  = IDLE_DATA;
         end
      end else if (state_q == HOLD) begin
         cnt_d  = cnt_dwell + 32'd1;
         data_d = Req_Data[{g, 3'b000} +: 8];
      end
   end

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed scoreboard bench for disp_arbiter with MCNT_DWELL=3; expectations follow
// DISP_ARB_PREEMPT_EN when the bench is built with it defined.
module tb_disp_arbiter;

   logic        Clk;
   logic        Reset_n;
   logic [3:0]  Req;
   logic [31:0] Req_Data;
   logic [3:0]  Gnt;
   logic [7:0]  Disp_Data;
   logic        Busy;

   int unsigned n_cmp;
   int unsigned n_err;

   typedef struct {
      logic [3:0] gnt;
      logic [7:0] data;
      string      tag;
   } exp_t;

   exp_t sb[$];

   disp_arbiter #(.MCNT_DWELL(3), .IDLE_DATA(8'h00)) dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .Req       (Req),
      .Req_Data  (Req_Data),
      .Gnt       (Gnt),
      .Disp_Data (Disp_Data),
      .Busy      (Busy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check_now(input string tag, input logic [3:0] eg, input logic [7:0] ed);
      n_cmp++;
      assert (Gnt === eg) else begin
         n_err++;
         $error("FAIL %s gnt observed=%b expected=%b", tag, Gnt, eg);
      end
      n_cmp++;
      assert (Busy === (|eg)) else begin
         n_err++;
         $error("FAIL %s busy observed=%b expected=%b", tag, Busy, |eg);
      end
      n_cmp++;
      assert (Disp_Data === ed) else begin
         n_err++;
         $error("FAIL %s data observed=%h expected=%h", tag, Disp_Data, ed);
      end
   endtask

   // Drive one cycle of inputs, queue what the next edge must produce, then compare.
   task automatic step(input string tag, input logic [3:0] req, input logic [31:0] rd,
                       input logic [3:0] eg, input logic [7:0] ed);
      exp_t e;
      Req      = req;
      Req_Data = rd;
      e.gnt = eg;
      e.data = ed;
      e.tag = tag;
      sb.push_back(e);
      @(posedge Clk);
      #1;
      if (sb.size() == 0) begin
         n_cmp++;
         n_err++;
         $error("FAIL %s scoreboard observed=empty expected=entry", tag);
      end else begin
         e = sb.pop_front();
         check_now(e.tag, e.gnt, e.data);
      end
   endtask

   task automatic do_reset();
      Reset_n = 1'b0;
      Req     = '0;
      #3;
      Reset_n = 1'b1;
   endtask

   initial begin
      logic [7:0]  rr_data [4];
      logic [31:0] rr_word;
      n_cmp    = 0;
      n_err    = 0;
      Reset_n  = 1'b0;
      Req      = '0;
      Req_Data = '0;
      repeat (2) @(posedge Clk);
      #1;
      check_now("reset_held", 4'b0000, 8'h00);
      Reset_n = 1'b1;

      for (int i = 0; i < 3; i++) step("reset_idle", 4'b0000, 32'h0, 4'b0000, 8'h00);

      // Single requester keeps the grant across dwell expiries.
      step("single_grant", 4'b0100, 32'h005A_0000, 4'b0100, 8'h5A);
      for (int i = 0; i < 8; i++) step("single_hold", 4'b0100, 32'h005A_0000, 4'b0100, 8'h5A);
      step("single_data", 4'b0100, 32'h003C_0000, 4'b0100, 8'h3C);
      step("single_rel", 4'b0000, 32'h003C_0000, 4'b0000, 8'h00);

      // Round-robin from reset: 0,1,2,3,0 each for 4 cycles.
      do_reset();
      rr_word = 32'hDDCC_BBAA;
      for (int i = 0; i < 4; i++) rr_data[i] = rr_word[8*i +: 8];
      for (int k = 0; k < 20; k++) begin
         int idx;
         idx = (k / 4) % 4;
         step("round_robin", 4'b1111, rr_word, 4'b0001 << idx, rr_data[idx]);
      end

      // Early release hands directly to source 3, then to idle.
      do_reset();
      step("early_grant1", 4'b0010, 32'h4433_2211, 4'b0010, 8'h22);
      step("early_hold1",  4'b0010, 32'h4433_2211, 4'b0010, 8'h22);
      step("early_to3",    4'b1000, 32'h4433_2211, 4'b1000, 8'h44);
      step("early_idle",   4'b0000, 32'h4433_2211, 4'b0000, 8'h00);

      // Asynchronous reset in the middle of a grant.
      do_reset();
      step("mid_grant", 4'b0010, 32'h4433_2211, 4'b0010, 8'h22);
      Reset_n = 1'b0;
      #1;
      check_now("mid_reset_async", 4'b0000, 8'h00);
      Reset_n = 1'b1;
      step("mid_regrant", 4'b0010, 32'h4433_2211, 4'b0010, 8'h22);

      // Dwell completion coinciding with holder drop: single arbitration.
      do_reset();
      step("coinc_grant0", 4'b0001, rr_word, 4'b0001, 8'hAA);
      for (int i = 0; i < 3; i++) step("coinc_hold0", 4'b0001, rr_word, 4'b0001, 8'hAA);
      step("coinc_to1", 4'b0010, rr_word, 4'b0010, 8'hBB);

      // Source 0 request while source 2 holds at cnt_dwell=1, without and with source 3.
      for (int v = 0; v < 2; v++) begin
         logic [3:0] rq;
         rq = (v == 0) ? 4'b0101 : 4'b1101;
         do_reset();
         step("pre_grant2", 4'b0100, rr_word, 4'b0100, 8'hCC);
         step("pre_hold2",  4'b0100, rr_word, 4'b0100, 8'hCC);
`ifdef DISP_ARB_PREEMPT_EN
         step("pre_s1", rq, rr_word, 4'b0001, 8'hAA);
         step("pre_s2", rq, rr_word, 4'b0001, 8'hAA);
         step("pre_s3", rq, rr_word, 4'b0001, 8'hAA);
`else
         step("pre_s1", rq, rr_word, 4'b0100, 8'hCC);
         step("pre_s2", rq, rr_word, 4'b0100, 8'hCC);
         if (v == 0) step("pre_s3", rq, rr_word, 4'b0001, 8'hAA);
         else        step("pre_s3", rq, rr_word, 4'b1000, 8'hDD);
`endif
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
